requant_scheduler: RTL
======================

# requant_scheduler

Shared requantization engine with per-channel scale control. It arbitrates round-robin among N_CH accumulator lanes (one per conv output channel) competing for a single multiply/shift/saturate pipeline, and holds a runtime-writable per-channel multiplier/shift table. It converts wide signed accumulator values to saturated OUT_W-bit activations tagged with their channel. It sits between the MAC array accumulators and the activation buffer writer.

## Interface
- N_CH, 4, number of requesting lanes/channels (power of 2, ≥2); CH_W = $clog2(N_CH)
- IN_W, 32, signed accumulator width
- OUT_W, 8, signed output width
- MULT_W, 16, unsigned multiplier width
- SHIFT_W, 6, shift-amount width
- DEF_MULT, 116, reset multiplier for every channel
- DEF_SHIFT, 16, reset shift for every channel

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write strobe for scale table
- cfg_ch  in  CH_W  table entry to write
- cfg_mult  in  MULT_W  multiplier value (unsigned)
- cfg_shift  in  SHIFT_W  arithmetic right-shift amount
- req_valid  in  N_CH  lane i has a value pending
- req_data  in  N_CH*IN_W  lane i data at bits [i*IN_W +: IN_W], signed
- req_ready  out  N_CH  lane i value accepted this cycle (one-hot or zero)
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  saturated signed result
- out_ch  out  CH_W  channel of out_data
- busy  out  1  any pipeline stage occupied

## Operation
- Scale table: N_CH entries {mult, shift}; on reset every entry = {DEF_MULT, DEF_SHIFT}; cfg_we writes entry cfg_ch at clock edge.
- Arbiter: round-robin pointer ptr (reset 0). Grant g = first i with req_valid[i], searching ptr, ptr+1, … mod N_CH. On a handshake to g, ptr ← g+1 mod N_CH (wraps N_CH-1 → 0). ptr unchanged when no handshake.
- advance = !out_valid || out_ready. req_ready[g] = advance && !(s1_valid && !advance) — i.e. req_ready[g] = advance; all other req_ready bits 0; all 0 if no req_valid.
- Stage 1 (on advance): s1_valid ← any handshake; capture data, g, and table entry for g as read before this edge's write (same-edge cfg write to g is not used by this sample).
- Stage 2 (on advance): out_valid ← s1_valid; product = signed data × zero-extended mult, width IN_W+MULT_W+1; shifted = product >>> shift (arithmetic, floor toward −∞, no rounding); out_data = clamp(shifted, −2^(OUT_W−1), 2^(OUT_W−1)−1); out_ch ← s1 channel.
- Stall: when !advance, s1 and output registers hold, out_data/out_ch stable, no req_ready.
- busy = s1_valid || out_valid.
- Reset (any time, including mid-stream): s1_valid, out_valid, out_data, out_ch, ptr, req_ready-driving state cleared to 0; table to defaults; in-flight samples discarded.

## Timing
- Handshake on edge k → out_valid high after edge k+1 (2-cycle latency) when out_ready held 1.
- Throughput 1 sample/cycle with out_ready=1; no bubble on lane switch.
- Config write at edge k affects handshakes at edge k+1 onward.
- Simultaneous cfg write to channel c and handshake from c at same edge: old value used.
- Outputs after reset: req_ready=0, out_valid=0, out_data=0, out_ch=0, busy=0.
- Shift ≥ product width yields 0 (non-negative) or −1 (negative) before clamp.

## Test plan
- Defaults, lane0 only, out_ready=1: data 1000 → out_data 1, out_ch 0, two cycles after handshake; −1000 → −2; 100000 → 127; −100000 → −128.
- Config ch2 {mult=256, shift=8}, lane2 data −50 → −50; lane0 data 1000 still → 1 (other entries untouched); same-edge write/handshake on ch2 uses old scale.
- All four req_valid held, out_ready=1 → grants/out_ch sequence 0,1,2,3,0,1…, one per cycle; with only lanes 1,3 valid → 1,3,1,3.
- out_ready low 5 cycles with full pipeline → out_data/out_ch stable, req_ready all 0, no sample lost or duplicated after release.
- rst_n asserted mid-stream (async, between edges) → out_valid, busy, req_ready drop immediately; table back to {116,16}; ptr=0 so lane 0 wins next.

Source files
------------

// File: rtl/requant_scheduler.sv
// Shared requantization engine: round-robin arbitration over N_CH accumulator lanes
// feeding one multiply / arithmetic-shift / saturate pipeline with a per-channel scale table.
module requant_scheduler #(
  parameter int N_CH      = 4,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MULT_W    = 16,
  parameter int SHIFT_W   = 6,
  parameter int DEF_MULT  = 116,
  parameter int DEF_SHIFT = 16,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [MULT_W-1:0]      cfg_mult,
  input  logic [SHIFT_W-1:0]     cfg_shift,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH*IN_W-1:0]   req_data,
  output logic [N_CH-1:0]        req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic                   busy
);

  localparam int PW = IN_W + MULT_W + 1;
  localparam logic signed [PW-1:0] SAT_HI = PW'(2**(OUT_W-1) - 1);
  localparam logic signed [PW-1:0] SAT_LO = -SAT_HI - PW'(1);

  typedef struct packed {
    logic [MULT_W-1:0]  mult;
    logic [SHIFT_W-1:0] shift;
  } scale_t;

  scale_t                  table_q [N_CH];
  logic [CH_W-1:0]         ptr;
  logic                    accept_en;
  logic                    s1_valid;
  logic signed [IN_W-1:0]  s1_data;
  logic [CH_W-1:0]         s1_ch;
  scale_t                  s1_scale;

  logic                    advance;
  logic                    grant_any;
  logic [CH_W-1:0]         grant_ch;
  logic                    handshake;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic [OUT_W-1:0]        sat;

  assign advance   = !out_valid || out_ready;
  assign handshake = grant_any && advance && accept_en;
  assign req_ready = handshake ? (N_CH'(1) << grant_ch) : '0;
  assign busy      = s1_valid || out_valid;

  // Scan downward so the lane closest to ptr is written last and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    grant_any = 1'b0;
    grant_ch  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_valid[ptr + CH_W'(k)]) begin
        // NOTE: blocking assignments in combinational logic; the loop relies on ordered overwrite.
        grant_any = 1'b1;
        grant_ch  = ptr + CH_W'(k);
      end
    end
  end

  always_comb begin
    prod    = $signed({{(PW-IN_W){s1_data[IN_W-1]}}, s1_data})
            * $signed({{(PW-MULT_W){1'b0}}, s1_scale.mult});
    shifted = prod >>> s1_scale.shift;
    sat     = shifted[OUT_W-1:0];
    if (shifted > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) sat = SAT_LO[OUT_W-1:0];
  end

  // NOTE: the scale table is a register array with an async reset because reset must restore
  // runtime-visible defaults; plain data storage would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++)
        table_q[i] <= '{mult: MULT_W'(DEF_MULT), shift: SHIFT_W'(DEF_SHIFT)};
    end else if (cfg_we) begin
      table_q[cfg_ch] <= '{mult: cfg_mult, shift: cfg_shift};
    end
  end

  // accept_en keeps req_ready low while reset is asserted, even though advance is then 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      accept_en <= 1'b0;
      ptr       <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_ch     <= '0;
      s1_scale  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      accept_en <= 1'b1;
      if (handshake) ptr <= grant_ch + CH_W'(1);
      if (advance) begin
        s1_valid  <= handshake;
        out_valid <= s1_valid;
        if (handshake) begin
          s1_data  <= req_data[grant_ch*IN_W +: IN_W];
          s1_ch    <= grant_ch;
          s1_scale <= table_q[grant_ch];
        end
        if (s1_valid) begin
          out_data <= sat;
          out_ch   <= s1_ch;
        end
      end
    end
  end

endmodule
